mdr_load_unit: RTL and testbench
================================

// Module: mdr_load_unit
// PURPOSE
//  Memory-read front end and memory data register (MDR) for the multicycle datapath.
//  - Accepts a load request from control and runs a valid/ack read on the data-memory bus.
//  - Extracts the addressed byte/halfword/word, then sign- or zero-extends it.
//  - Holds the result on MDROut, which feeds the MemtoReg write-data select ahead of the register file.
// PARAMETERS
//  DATA_WIDTH  32  data bus and MDROut width (lane logic fixed for 32)
//  ADDR_WIDTH  32  byte address width
//  TIMEOUT     16  max cycles mem_req stays high waiting for mem_ack (>=1)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  MemRead      in   1           load request from control, sampled in IDLE only
//  Addr         in   ADDR_WIDTH  byte address of the load
//  LoadSize     in   2           00 word, 01 half, 10 byte, 11 illegal
//  LoadUnsigned in   1           1 zero-extend, 0 sign-extend (byte/half)
//  mem_req      out  1           read request to data memory
//  mem_addr     out  ADDR_WIDTH  word-aligned address {Addr[ADDR_WIDTH-1:2],2'b00}
//  mem_ack      in   1           memory returns data this cycle (valid only while mem_req=1)
//  mem_rdata    in   DATA_WIDTH  read data, little-endian lanes, sampled when mem_ack=1
//  MDROut       out  DATA_WIDTH  registered, extended load result
//  MDRValid     out  1           1-cycle pulse: MDROut updated this cycle
//  Busy         out  1           1 in any non-IDLE state
//  MisalignErr  out  1           1-cycle pulse: misaligned or illegal-size request
//  TimeoutErr   out  1           1-cycle pulse: no ack within TIMEOUT cycles
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - All outputs 0 immediately; state IDLE; counter 0; latched request fields cleared.
//  - Applies mid-transaction: mem_req drops without waiting for a clock edge, and any late mem_ack is ignored.
//  States: IDLE, WAIT, DONE, ERR.
//  IDLE:
//  - MemRead=1 latches Addr[1:0], LoadSize and LoadUnsigned, and registers mem_addr.
//  - Illegal request goes to ERR: LoadSize=11, half with Addr[0]=1, or word with Addr[1:0]!=0.
//  - Otherwise goes to WAIT.
//  WAIT:
//  - mem_req=1 and mem_addr are held stable; the counter increments every cycle.
//  - mem_ack=1 captures extracted data into MDROut and goes to DONE.
//  - If no ack arrives in TIMEOUT cycles, go to ERR with the timeout flag set.
//  - An ack in the TIMEOUT-th cycle counts as success.
//  DONE: MDRValid=1, mem_req=0, then IDLE.
//  ERR: exactly one of MisalignErr/TimeoutErr =1; MDROut unchanged; mem_req=0; then IDLE.
//  Min latency: MemRead at edge N -> mem_req high after N.
//  - With ack in that cycle, MDROut and MDRValid are valid after edge N+2.
//  - Misalign: MemRead at edge N -> MisalignErr high after edge N+1; mem_req never asserted.
//  Extraction, o = latched Addr[1:0]:
//  - byte = rdata[8*o+7:8*o]; half = rdata[16*o[1]+15:16*o[1]]; word = rdata.
//  - Extend to DATA_WIDTH: sign bit replicated if LoadUnsigned=0, zeros if 1.
//  MemRead outside IDLE is ignored, not queued. mem_ack outside WAIT is ignored.
//  Counter width is $clog2(TIMEOUT+1). It is reset to 0 on every IDLE->WAIT transition.
//  Busy=1 in WAIT, DONE, ERR; control must hold the FSM state while Busy=1.
// TESTING
//  - Word load Addr=0x100, ack 2 cycles after req, rdata=0xDEADBEEF:
//    mem_addr=0x100, mem_req high 3 cycles, MDROut=0xDEADBEEF, MDRValid 1 cycle.
//  - Byte Addr=0x103, rdata=0x80FF1234: signed -> 0xFFFFFF80; unsigned -> 0x00000080; mem_addr=0x100.
//  - Half Addr=0x102, rdata=0x8001ABCD: signed -> 0xFFFF8001; Addr=0x100 unsigned -> 0x0000ABCD.
//  - Half Addr=0x101, or LoadSize=11:
//    MisalignErr pulse 1 cycle, mem_req stays 0, MDROut keeps its previous value.
//  - TIMEOUT=16, no ack: mem_req high exactly 16 cycles, then TimeoutErr pulse, Busy=0 next cycle.
//    Repeat with ack in cycle 16 -> success, no error.
//  - rst_n low while in WAIT: mem_req=0 and MDROut=0 immediately, no MDRValid.
//    MemRead pulsed while Busy=1 -> no second transaction.

Source files
------------

// File: rtl/mdr_load_unit.sv
// Memory-read front end and memory data register for the multicycle datapath:
// runs one valid/ack read per load, then extracts and extends the addressed lane into MDROut.
module mdr_load_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [1:0]            LoadSize,
    input  logic                  LoadUnsigned,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] MDROut,
    output logic                  MDRValid,
    output logic                  Busy,
    output logic                  MisalignErr,
    output logic                  TimeoutErr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  tout_flag_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] raw_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_req_q;
    logic                  busy_q;
    logic                  mdr_valid_q;
    logic                  misalign_q;
    logic                  timeout_q;
    logic                  illegal;

    // Lane select plus sign/zero extension; LoadSize 00 word, 01 half, 10 byte.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b10:   r = {{(DATA_WIDTH-8){~uns & b[7]}}, b};
            2'b01:   r = {{(DATA_WIDTH-16){~uns & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    always_comb begin
        illegal = 1'b0;
        case (LoadSize)
            2'b11:   illegal = 1'b1;
            2'b01:   illegal = Addr[0];
            2'b00:   illegal = |Addr[1:0];
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            tout_flag_q <= 1'b0;
            cnt_q       <= '0;
            raw_q       <= '0;
            mdr_q       <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            mdr_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            mdr_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MemRead) begin
                        off_q      <= Addr[1:0];
                        size_q     <= LoadSize;
                        uns_q      <= LoadUnsigned;
                        mem_addr_q <= {Addr[ADDR_WIDTH-1:2], 2'b00};
                        busy_q     <= 1'b1;
                        if (illegal) begin
                            tout_flag_q <= 1'b0;
                            state_q     <= S_ERR;
                        end else begin
                            cnt_q     <= '0;
                            mem_req_q <= 1'b1;
                            state_q   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        raw_q     <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tout_flag_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state_q     <= S_ERR;
                    end
                end
                S_DONE: begin
                    mdr_q       <= extract(raw_q, off_q, size_q, uns_q);
                    mdr_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    timeout_q  <= tout_flag_q;
                    misalign_q <= ~tout_flag_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign MDROut      = mdr_q;
    assign MDRValid    = mdr_valid_q;
    assign Busy        = busy_q;
    assign MisalignErr = misalign_q;
    assign TimeoutErr  = timeout_q;

endmodule

// File: tb/tb_mdr_load_unit.sv
// Bench for mdr_load_unit: directed vector table, reset/busy corner sequences,
// and randomized loads checked against a lane/extension reference model.
module tb_mdr_load_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic [31:0] Addr;
    logic [1:0]  LoadSize;
    logic        LoadUnsigned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] MDROut;
    logic        MDRValid;
    logic        Busy;
    logic        MisalignErr;
    logic        TimeoutErr;

    int checks = 0;
    int errors = 0;

    mdr_load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .Addr(Addr),
        .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .MDROut(MDROut), .MDRValid(MDRValid),
        .Busy(Busy), .MisalignErr(MisalignErr), .TimeoutErr(TimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        int          ack_at;
        logic [31:0] rdata;
        logic [31:0] exp_mdr;
        int          exp_req;
        int          exp_val;
        int          exp_mis;
        int          exp_to;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one load and act as memory, acking in request cycle ack_at (0 = never).
    task automatic run_txn(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input int ack_at, input logic [31:0] rdata, input bit poke,
                           output int req_n, output int val_n, output int mis_n,
                           output int to_n, output int lat, output int bad_addr,
                           output logic [31:0] mdr_end);
        int t;
        bit done;
        req_n = 0; val_n = 0; mis_n = 0; to_n = 0; lat = 0; bad_addr = 0;
        t = 0;
        done = 0;
        @(negedge clk);
        MemRead = 1'b1; Addr = addr; LoadSize = size; LoadUnsigned = uns; mem_ack = 1'b0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
            MemRead = poke && (t <= ack_at + 1);
            Addr = $urandom;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== {addr[31:2], 2'b00}) bad_addr++;
            end
            mem_ack   = mem_req && (req_n == ack_at);
            mem_rdata = mem_ack ? rdata : $urandom;
            if (MDRValid)    val_n++;
            if (MisalignErr) mis_n++;
            if (TimeoutErr)  to_n++;
            if (!Busy) begin
                done = 1;
                lat  = t;
            end
        end
        mem_ack = 1'b0;
        MemRead = 1'b0;
        mdr_end = MDROut;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_end: Busy still 1 after %0d cycles, expected idle", t);
        end
    endtask

    task automatic check_txn(input string tag, input int req_n, input int val_n, input int mis_n,
                             input int to_n, input int lat, input int bad_addr,
                             input logic [31:0] mdr, input vec_t v);
        int exp_lat;
        exp_lat = (v.exp_mis != 0) ? 2 : (v.exp_to != 0) ? TO + 2 : v.ack_at + 2;
        chk({tag, "_mdr"}, mdr, v.exp_mdr);
        chk({tag, "_reqcycles"}, req_n, v.exp_req);
        chk({tag, "_valid"}, val_n, v.exp_val);
        chk({tag, "_misalign"}, mis_n, v.exp_mis);
        chk({tag, "_timeout"}, to_n, v.exp_to);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_memaddr"}, bad_addr, 0);
    endtask

    // Reference: apply the load rules to a whole transaction.
    function automatic vec_t model(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                   input int ack_at, input logic [31:0] rdata,
                                   input logic [31:0] prev_mdr);
        vec_t v;
        int off;
        logic [31:0] val;
        bit bad;
        v.addr = addr; v.size = size; v.uns = uns; v.ack_at = ack_at; v.rdata = rdata;
        v.exp_mdr = prev_mdr; v.exp_req = 0; v.exp_val = 0; v.exp_mis = 0; v.exp_to = 0;
        off = int'(addr % 4);
        bad = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd0 && off != 0);
        if (bad) begin
            v.exp_mis = 1;
        end else if (ack_at < 1 || ack_at > TO) begin
            v.exp_req = TO;
            v.exp_to  = 1;
        end else begin
            if (size == 2'd2) begin
                val = (rdata >> (8 * off)) & 32'hFF;
                if (!uns && val >= 32'h80) val = val | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                val = (rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (!uns && val >= 32'h8000) val = val | 32'hFFFF_0000;
            end else begin
                val = rdata;
            end
            v.exp_mdr = val;
            v.exp_req = ack_at;
            v.exp_val = 1;
        end
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        int req_n, val_n, mis_n, to_n, lat, bad_addr, cnt;
        logic [31:0] mdr;
        logic [31:0] mdr_model;
        vec_t v;

        vecs[0]  = '{32'h100, 2'd0, 1'b0, 3,  32'hDEADBEEF, 32'hDEADBEEF, 3,  1, 0, 0};
        vecs[1]  = '{32'h103, 2'd2, 1'b0, 1,  32'h80FF1234, 32'hFFFFFF80, 1,  1, 0, 0};
        vecs[2]  = '{32'h103, 2'd2, 1'b1, 1,  32'h80FF1234, 32'h00000080, 1,  1, 0, 0};
        vecs[3]  = '{32'h102, 2'd1, 1'b0, 2,  32'h8001ABCD, 32'hFFFF8001, 2,  1, 0, 0};
        vecs[4]  = '{32'h100, 2'd1, 1'b1, 1,  32'h8001ABCD, 32'h0000ABCD, 1,  1, 0, 0};
        vecs[5]  = '{32'h101, 2'd1, 1'b0, 1,  32'h11111111, 32'h0000ABCD, 0,  0, 1, 0};
        vecs[6]  = '{32'h100, 2'd3, 1'b0, 1,  32'h22222222, 32'h0000ABCD, 0,  0, 1, 0};
        vecs[7]  = '{32'h102, 2'd0, 1'b0, 1,  32'h33333333, 32'h0000ABCD, 0,  0, 1, 0};
        vecs[8]  = '{32'h101, 2'd2, 1'b1, 2,  32'h12345678, 32'h00000056, 2,  1, 0, 0};
        vecs[9]  = '{32'h200, 2'd0, 1'b0, 0,  32'h44444444, 32'h00000056, 16, 0, 0, 1};
        vecs[10] = '{32'h204, 2'd0, 1'b0, 16, 32'h13579BDF, 32'h13579BDF, 16, 1, 0, 0};
        vecs[11] = '{32'h100, 2'd2, 1'b0, 1,  32'h0000007F, 32'h0000007F, 1,  1, 0, 0};

        rst_n = 1'b0; MemRead = 1'b0; Addr = '0; LoadSize = '0; LoadUnsigned = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {29'd0, mem_req, MDRValid, Busy} | mem_addr | MDROut, 32'd0);
        chk("reset_errs", {30'd0, MisalignErr, TimeoutErr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].ack_at, vecs[i].rdata, 1'b0,
                    req_n, val_n, mis_n, to_n, lat, bad_addr, mdr);
            check_txn($sformatf("vec%0d", i), req_n, val_n, mis_n, to_n, lat, bad_addr, mdr, vecs[i]);
        end

        // Asynchronous reset in the middle of a WAIT, with a late ack during and after it.
        @(negedge clk);
        MemRead = 1'b1; Addr = 32'h300; LoadSize = 2'd0; LoadUnsigned = 1'b0;
        @(negedge clk);
        MemRead = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_mdr", MDROut, 32'd0);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (MDRValid || mem_req || Busy) cnt++;
        end
        mem_ack = 1'b0;
        chk("midrst_late_ack", cnt, 0);
        chk("midrst_mdr_after", MDROut, 32'd0);

        // MemRead held high while Busy must not start a second transaction.
        v = model(32'h400, 2'd0, 1'b0, 3, 32'h11112222, 32'd0);
        run_txn(v.addr, v.size, v.uns, v.ack_at, v.rdata, 1'b1, req_n, val_n, mis_n, to_n, lat, bad_addr, mdr);
        check_txn("busy_poke", req_n, val_n, mis_n, to_n, lat, bad_addr, mdr, v);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_req || Busy) cnt++;
        end
        chk("busy_poke_no_second", cnt, 0);
        mdr_model = v.exp_mdr;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [1:0]  rs;
            int          ack;
            ra = $urandom;
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'd0) ra[1:0] = 2'b00;
                if (rs == 2'd1) ra[0] = 1'b0;
            end
            ack = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
            v = model(ra, rs, 1'($urandom_range(0, 1)), ack, $urandom, mdr_model);
            run_txn(v.addr, v.size, v.uns, v.ack_at, v.rdata, 1'($urandom_range(0, 1)) && ack != 0,
                    req_n, val_n, mis_n, to_n, lat, bad_addr, mdr);
            check_txn($sformatf("rnd%0d", i), req_n, val_n, mis_n, to_n, lat, bad_addr, mdr, v);
            mdr_model = v.exp_mdr;
            repeat (2) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
